// File: rtl/tx_ltssm_link_training.sv
// Transmit-side LTSSM substate engine for Detect and Polling: runs receiver detection,
// requests TS1/TS2 ordered sets and reports substate completion back to mainLTSSM.
module tx_ltssm_link_training #(
  parameter int unsigned DETECT_QUIET_CYCLES = 1000,
  parameter int unsigned POLL_TIMEOUT_CYCLES = 24000,
  parameter int unsigned POLL_ACTIVE_TS1     = 1024,
  parameter int unsigned POLL_CFG_TS2_AFTER  = 16,
  parameter int unsigned TIMER_W             = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] substate,
  input  logic       rxDetectDone,
  input  logic [4:0] rxDetectLanes,
  input  logic       rxTs1Seen,
  input  logic       rxTs2Seen,
  input  logic       osReady,
  output logic       osValid,
  output logic [1:0] osType,
  output logic       rxDetectReq,
  output logic [4:0] numberOfDetectedLanes,
  output logic       writeNumberOfDetectedLanes,
  output logic       finishTx,
  output logic [3:0] gotoTx
);

  localparam int unsigned SUB_W   = 4;
  localparam int unsigned LANE_W  = 5;
  localparam int unsigned TSCNT_W = 11;
  localparam int unsigned OS_W    = 2;

  typedef enum logic [SUB_W-1:0] {
    detectQuiet                 = 4'd0,
    detectActive                = 4'd1,
    pollingActive               = 4'd2,
    pollingConfiguration        = 4'd3,
    configurationLinkWidthStart = 4'd4
  } substate_e;

  localparam logic [OS_W-1:0] OS_NONE = 2'd0;
  localparam logic [OS_W-1:0] OS_TS1  = 2'd1;
  localparam logic [OS_W-1:0] OS_TS2  = 2'd2;

  logic [SUB_W-1:0]   substateQ;
  logic [TIMER_W-1:0] timer, timerD;
  logic [TSCNT_W-1:0] tsCount, tsCountD;
  logic               ts2Latch, ts2LatchD;
  logic               finishReg, finishD;
  logic [SUB_W-1:0]   gotoReg, gotoD;
  logic               osValidD;
  logic [OS_W-1:0]    osTypeD;
  logic               rxDetectReqD;
  logic [LANE_W-1:0]  lanesD;
  logic               writeLanesD;
  logic               entry, accept, ts1Done, ts2Done, timeout;

  assign entry   = (substate != substateQ);
  assign accept  = osValid && osReady;
  assign ts1Done = (tsCount >= TSCNT_W'(POLL_ACTIVE_TS1)) && rxTs1Seen;
  assign ts2Done = ts2Latch && (tsCount >= TSCNT_W'(POLL_CFG_TS2_AFTER));
  assign timeout = (timer == TIMER_W'(POLL_TIMEOUT_CYCLES - 1));

  // A finish raised for the old substate is hidden in the cycle mainLTSSM moves on.
  assign finishTx = !reset && finishReg && !entry;
  assign gotoTx   = reset ? '0 : (finishTx ? gotoReg : substate);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      substateQ                  <= detectQuiet;
      timer                      <= '0;
      tsCount                    <= '0;
      ts2Latch                   <= 1'b0;
      finishReg                  <= 1'b0;
      gotoReg                    <= '0;
      osValid                    <= 1'b0;
      osType                     <= OS_NONE;
      rxDetectReq                <= 1'b0;
      numberOfDetectedLanes      <= '0;
      writeNumberOfDetectedLanes <= 1'b0;
    end else begin
      substateQ                  <= substate;
      timer                      <= timerD;
      tsCount                    <= tsCountD;
      ts2Latch                   <= ts2LatchD;
      finishReg                  <= finishD;
      gotoReg                    <= gotoD;
      osValid                    <= osValidD;
      osType                     <= osTypeD;
      rxDetectReq                <= rxDetectReqD;
      numberOfDetectedLanes      <= lanesD;
      writeNumberOfDetectedLanes <= writeLanesD;
    end
  end

  always_comb begin
    timerD       = timer;
    tsCountD     = tsCount;
    ts2LatchD    = ts2Latch;
    finishD      = finishReg;
    gotoD        = gotoReg;
    osValidD     = osValid;
    osTypeD      = osType;
    rxDetectReqD = 1'b0;
    lanesD       = numberOfDetectedLanes;
    writeLanesD  = 1'b0;

    if (entry) begin
      // Entry wins over any exit condition of the substate being left.
      timerD       = '0;
      tsCountD     = '0;
      ts2LatchD    = 1'b0;
      finishD      = 1'b0;
      gotoD        = '0;
      osValidD     = (substate == pollingActive) || (substate == pollingConfiguration);
      osTypeD      = (substate == pollingActive)        ? OS_TS1 :
                     (substate == pollingConfiguration) ? OS_TS2 : OS_NONE;
      rxDetectReqD = (substate == detectActive);
    end else begin
      if (substateQ <= pollingConfiguration) begin
        if (timer != {TIMER_W{1'b1}}) timerD = timer + TIMER_W'(1);
      end else begin
        timerD = '0;
      end
      if (accept && (tsCount != {TSCNT_W{1'b1}})) tsCountD = tsCount + TSCNT_W'(1);

      case (substateQ)
        detectQuiet: begin
          if (!finishReg && (timer == TIMER_W'(DETECT_QUIET_CYCLES - 1))) begin
            finishD = 1'b1;
            gotoD   = detectActive;
          end
        end
        detectActive: begin
          if (!finishReg && rxDetectDone) begin
            lanesD      = rxDetectLanes;
            writeLanesD = 1'b1;
            finishD     = 1'b1;
            gotoD       = (rxDetectLanes != '0) ? pollingActive : detectQuiet;
          end
        end
        pollingActive: begin
          if (!finishReg && (ts1Done || timeout)) begin
            finishD = 1'b1;
            gotoD   = ts1Done ? pollingConfiguration : detectQuiet;
          end
        end
        pollingConfiguration: begin
          // TS2 counting restarts with the cycle rxTs2Seen is first observed.
          if (!ts2Latch && rxTs2Seen) begin
            ts2LatchD = 1'b1;
            tsCountD  = accept ? TSCNT_W'(1) : '0;
          end
          if (!finishReg && (ts2Done || timeout)) begin
            finishD = 1'b1;
            gotoD   = ts2Done ? configurationLinkWidthStart : detectQuiet;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_ltssm_link_training.sv
// Randomized self-checking bench for tx_ltssm_link_training; expected finish timing and
// targets come from per-scenario counting over pre-generated input traces.
module tb_tx_ltssm_link_training;

  localparam int unsigned DQ   = 8;
  localparam int unsigned TO   = 50;
  localparam int unsigned NTS1 = 16;
  localparam int unsigned NTS2 = 16;
  localparam int          LEN  = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] substate;
  logic       rxDetectDone;
  logic [4:0] rxDetectLanes;
  logic       rxTs1Seen;
  logic       rxTs2Seen;
  logic       osReady;
  logic       osValid;
  logic [1:0] osType;
  logic       rxDetectReq;
  logic [4:0] numberOfDetectedLanes;
  logic       writeNumberOfDetectedLanes;
  logic       finishTx;
  logic [3:0] gotoTx;

  int checks = 0;
  int errors = 0;

  tx_ltssm_link_training #(
    .DETECT_QUIET_CYCLES(DQ), .POLL_TIMEOUT_CYCLES(TO), .POLL_ACTIVE_TS1(NTS1),
    .POLL_CFG_TS2_AFTER(NTS2), .TIMER_W(24)
  ) dut (
    .clk(clk), .reset(reset), .substate(substate), .rxDetectDone(rxDetectDone),
    .rxDetectLanes(rxDetectLanes), .rxTs1Seen(rxTs1Seen), .rxTs2Seen(rxTs2Seen),
    .osReady(osReady), .osValid(osValid), .osType(osType), .rxDetectReq(rxDetectReq),
    .numberOfDetectedLanes(numberOfDetectedLanes),
    .writeNumberOfDetectedLanes(writeNumberOfDetectedLanes),
    .finishTx(finishTx), .gotoTx(gotoTx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; substate = 4'd0; rxDetectDone = 1'b0; rxDetectLanes = '0;
    rxTs1Seen = 1'b0; rxTs2Seen = 1'b0; osReady = 1'b0;
    tick(); tick();
    #1;
    checks++;
    if ({osValid, osType, rxDetectReq, numberOfDetectedLanes, writeNumberOfDetectedLanes,
         finishTx, gotoTx} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required all zero", {osValid, osType, rxDetectReq,
               numberOfDetectedLanes, writeNumberOfDetectedLanes, finishTx, gotoTx});
    end
  endtask

  // Timer starts at 0 in the first cycle out of reset; finish follows the cycle timer == DQ-1.
  task automatic test_detect_quiet();
    tick();
    reset = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) tick();
      #1;
      checks++;
      if (finishTx !== (c >= DQ) || gotoTx !== ((c >= DQ) ? 4'd1 : 4'd0) || osValid !== 1'b0) begin
        errors++;
        $display("FAIL detect_quiet c=%0d: finish=%b goto=%0d osValid=%b required finish=%b goto=%0d osValid=0",
                 c, finishTx, gotoTx, osValid, c >= DQ, (c >= DQ) ? 1 : 0);
      end
    end
  endtask

  task automatic test_detect_active(input logic [4:0] lanes, input int delay);
    int expGoto;
    expGoto = (lanes != 0) ? 2 : 0;
    tick(); substate = 4'd0;
    tick(); substate = 4'd1;
    #1;
    checks++;
    if (finishTx !== 1'b0 || gotoTx !== 4'd1) begin
      errors++;
      $display("FAIL detect_active_entry: finish=%b goto=%0d required 0/1", finishTx, gotoTx);
    end
    for (int t = 1; t <= delay + 3; t++) begin
      tick();
      rxDetectDone  = (t == delay);
      rxDetectLanes = (t == delay) ? lanes : 5'($urandom_range(31));
      #1;
      checks++;
      if (rxDetectReq !== (t == 1) || writeNumberOfDetectedLanes !== (t == delay + 1) ||
          finishTx !== (t > delay) || gotoTx !== ((t > delay) ? 4'(expGoto) : 4'd1) ||
          (t > delay && numberOfDetectedLanes !== lanes)) begin
        errors++;
        $display("FAIL detect_active t=%0d lanes=%0d: req=%b wr=%b finish=%b goto=%0d numLanes=%0d required req=%b wr=%b finish=%b goto=%0d",
                 t, lanes, rxDetectReq, writeNumberOfDetectedLanes, finishTx, gotoTx,
                 numberOfDetectedLanes, t == 1, t == delay + 1, t > delay,
                 (t > delay) ? expGoto : 1);
      end
    end
    rxDetectDone = 1'b0;
  endtask

  // pollingActive: TS1 accepted before cycle t are counted; exit at first cycle with
  // enough TS1 plus rxTs1Seen, or at the last timeout cycle; finish shows next cycle.
  task automatic test_polling_active(input int ts1On, input int readyPct);
    bit rdy [LEN];
    int acc, exitT, expGoto;
    acc = 0; exitT = -1; expGoto = 0;
    for (int t = 0; t < LEN; t++) rdy[t] = ($urandom_range(99) < readyPct);
    for (int t = 1; t < LEN; t++) begin
      if (exitT < 0) begin
        if (acc >= NTS1 && t >= ts1On) begin exitT = t; expGoto = 3; end
        else if (t - 1 == TO - 1) begin exitT = t; expGoto = 0; end
      end
      acc += int'(rdy[t]);
    end
    tick(); substate = 4'd0; rxTs1Seen = 1'b0;
    tick(); substate = 4'd2;
    for (int t = 1; t <= exitT + 3; t++) begin
      tick();
      osReady = rdy[t];
      rxTs1Seen = (t >= ts1On);
      #1;
      checks++;
      if (osValid !== 1'b1 || osType !== 2'd1 || finishTx !== (t > exitT) ||
          gotoTx !== ((t > exitT) ? 4'(expGoto) : 4'd2)) begin
        errors++;
        $display("FAIL polling_active ts1On=%0d t=%0d: osValid=%b osType=%0d finish=%b goto=%0d required 1/1/%b/%0d",
                 ts1On, t, osValid, osType, finishTx, gotoTx, t > exitT,
                 (t > exitT) ? expGoto : 2);
      end
    end
    rxTs1Seen = 1'b0;
  endtask

  // pollingConfiguration: TS2 accepted from the cycle rxTs2Seen rises are counted;
  // exit once enough have been counted, or at the timeout cycle.
  task automatic test_polling_config(input bit toggle, input int r, input int readyPct);
    bit rdy [LEN];
    int acc, exitT, expGoto;
    acc = 0; exitT = -1; expGoto = 0;
    for (int t = 0; t < LEN; t++)
      rdy[t] = toggle ? bit'(t % 2) : ($urandom_range(99) < readyPct);
    for (int t = 1; t < LEN; t++) begin
      if (exitT < 0) begin
        if (t > r && acc >= NTS2) begin exitT = t; expGoto = 4; end
        else if (t - 1 == TO - 1) begin exitT = t; expGoto = 0; end
      end
      if (t >= r) acc += int'(rdy[t]);
    end
    tick(); substate = 4'd0; rxTs2Seen = 1'b0;
    tick(); substate = 4'd3;
    for (int t = 1; t <= exitT + 3; t++) begin
      tick();
      osReady = rdy[t];
      rxTs2Seen = (t >= r);
      #1;
      checks++;
      if (osValid !== 1'b1 || osType !== 2'd2 || finishTx !== (t > exitT) ||
          gotoTx !== ((t > exitT) ? 4'(expGoto) : 4'd3)) begin
        errors++;
        $display("FAIL polling_config r=%0d t=%0d: osValid=%b osType=%0d finish=%b goto=%0d required 1/2/%b/%0d",
                 r, t, osValid, osType, finishTx, gotoTx, t > exitT,
                 (t > exitT) ? expGoto : 3);
      end
    end
    rxTs2Seen = 1'b0;
  endtask

  task automatic test_idle_states();
    logic [3:0] s;
    for (int k = 0; k < 4; k++) begin
      s = 4'($urandom_range(15, 4));
      tick(); substate = 4'd0;
      tick(); substate = s;
      for (int t = 1; t <= 6; t++) begin
        tick();
        osReady = 1'($urandom_range(1));
        #1;
        checks++;
        if (osValid !== 1'b0 || osType !== 2'd0 || finishTx !== 1'b0 || gotoTx !== s) begin
          errors++;
          $display("FAIL idle_state s=%0d t=%0d: osValid=%b osType=%0d finish=%b goto=%0d required 0/0/0/%0d",
                   s, t, osValid, osType, finishTx, gotoTx, s);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    tick(); substate = 4'd0;
    tick(); substate = 4'd2; osReady = 1'b1;
    for (int t = 0; t < 5; t++) tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({osValid, osType, rxDetectReq, numberOfDetectedLanes, writeNumberOfDetectedLanes,
         finishTx, gotoTx} !== 15'd0) begin
      errors++;
      $display("FAIL reset_mid: got %b required all zero", {osValid, osType, rxDetectReq,
               numberOfDetectedLanes, writeNumberOfDetectedLanes, finishTx, gotoTx});
    end
  endtask

  task automatic test_change_during_finish();
    tick();
    substate = 4'd0; osReady = 1'b0; reset = 1'b0;
    for (int c = 1; c <= DQ + 2; c++) tick();
    #1;
    checks++;
    if (finishTx !== 1'b1 || gotoTx !== 4'd1) begin
      errors++;
      $display("FAIL held_finish: finish=%b goto=%0d required 1/1", finishTx, gotoTx);
    end
    tick();
    substate = 4'd1;
    #1;
    checks++;
    if (finishTx !== 1'b0 || gotoTx !== 4'd1) begin
      errors++;
      $display("FAIL change_masks_finish: finish=%b goto=%0d required 0/1", finishTx, gotoTx);
    end
  endtask

  initial begin
    test_reset();
    test_detect_quiet();
    test_detect_active(5'd4, 3);
    test_detect_active(5'd0, 5);
    for (int k = 0; k < 3; k++)
      test_detect_active(5'($urandom_range(31)), int'($urandom_range(8, 1)));
    test_polling_active(1, 100);
    test_polling_active(1000, 100);
    test_polling_active(50, 100);
    test_polling_active(int'($urandom_range(40, 1)), 70);
    test_polling_config(1'b1, 10, 0);
    test_polling_config(1'b0, int'($urandom_range(12, 1)), 80);
    test_idle_states();
    test_reset_mid();
    test_change_during_finish();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
